// File: rtl/turn_arbiter.sv
// turn_arbiter: alternates black/white move requests, checks range and occupancy,
// issues placements to the board FSM and tracks passes, timeouts and game over.
module turn_arbiter #(
    parameter int         BOARD_SIZE   = 9,
    parameter int         TURN_TIMEOUT = 0,
    parameter logic [7:0] PASS_CODE    = 8'hFF
) (
    input  logic                                          clk_in,
    input  logic                                          reset,
    input  logic                                          b_req_valid,
    input  logic [7:0]                                    b_req_move,
    output logic                                          b_req_ready,
    input  logic                                          w_req_valid,
    input  logic [7:0]                                    w_req_move,
    output logic                                          w_req_ready,
    input  logic [BOARD_SIZE-1:0][BOARD_SIZE-1:0][1:0]    board,
    output logic                                          move_avail,
    output logic [7:0]                                    move,
    output logic [1:0]                                    move_color,
    output logic [1:0]                                    turn,
    output logic                                          reject,
    output logic [1:0]                                    reject_code,
    output logic                                          timeout,
    output logic                                          game_over
);
    localparam int TW = TURN_TIMEOUT > 0 ? $clog2(TURN_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TURN_TIMEOUT > 0 ? TURN_TIMEOUT - 1 : 0);
    localparam logic [3:0] BS = 4'(BOARD_SIZE);

    typedef enum logic [2:0] {WAIT_REQ, CHECK, ISSUE, SETTLE, GAME_OVER} state_t;

    state_t        state;
    logic [1:0]    pass_cnt, pass_inc;
    logic [TW-1:0] timer;
    logic          hs, expire, off_board;
    logic [3:0]    row, col;

    assign b_req_ready = state == WAIT_REQ && turn == 2'b01;
    assign w_req_ready = state == WAIT_REQ && turn == 2'b10;
    assign hs          = (b_req_ready && b_req_valid) || (w_req_ready && w_req_valid);
    // A handshake in the expiry cycle takes priority over the timeout.
    assign expire      = TURN_TIMEOUT > 0 && state == WAIT_REQ && timer == T_LAST;
    assign timeout     = expire && !hs && !reset;
    assign row         = move[7:4];
    assign col         = move[3:0];
    assign off_board   = row >= BS || col >= BS;
    assign pass_inc    = pass_cnt == 2'd2 ? 2'd2 : pass_cnt + 2'd1;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= WAIT_REQ;
            turn        <= 2'b01;
            move        <= 8'h00;
            move_color  <= 2'b00;
            move_avail  <= 1'b0;
            reject      <= 1'b0;
            reject_code <= 2'b00;
            game_over   <= 1'b0;
            pass_cnt    <= 2'd0;
            timer       <= '0;
        end else begin
            move_avail <= 1'b0;
            reject     <= 1'b0;
            case (state)
                WAIT_REQ: begin
                    if (hs) begin
                        move  <= turn == 2'b01 ? b_req_move : w_req_move;
                        state <= CHECK;
                    end else if (expire) begin
                        pass_cnt <= pass_inc;
                        state    <= SETTLE;
                    end else if (TURN_TIMEOUT > 0) begin
                        timer <= timer + TW'(1);
                    end
                end
                CHECK: begin
                    if (move == PASS_CODE) begin
                        pass_cnt <= pass_inc;
                        state    <= SETTLE;
                    end else if (off_board || board[row][col] != 2'b00) begin
                        reject      <= 1'b1;
                        reject_code <= off_board ? 2'b01 : 2'b10;
                        state       <= WAIT_REQ;
                    end else begin
                        pass_cnt   <= 2'd0;
                        move_avail <= 1'b1;
                        move_color <= turn;
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= SETTLE;
                SETTLE: begin
                    turn      <= ~turn;
                    timer     <= '0;
                    game_over <= pass_cnt == 2'd2;
                    state     <= pass_cnt == 2'd2 ? GAME_OVER : WAIT_REQ;
                end
                default: state <= GAME_OVER;
            endcase
        end
    end
endmodule

// File: doc/turn_arbiter.md
# turn_arbiter

Turn controller for the 9x9 Go board datapath. It takes move requests from a black source and a white source over valid/ready handshakes and enforces strict alternation. Each request is checked against the current board for range and occupancy. An accepted stone placement is issued to the board FSM as a one-cycle `move_avail` pulse with `move`. It also counts passes and per-turn timeouts, and declares game over after two consecutive passes.

## Interface
- `BOARD_SIZE`, default 9: board edge length; legal row/col are 0..BOARD_SIZE-1.
- `TURN_TIMEOUT`, default 0: cycles allowed in WAIT_REQ per turn; 0 disables timeout. Timer width is $clog2(TURN_TIMEOUT+1), minimum 1.
- `PASS_CODE`, default 8'hFF: move encoding for a pass.

- `clk_in`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; all state cleared immediately
- `b_req_valid`  in  1  black source has a move
- `b_req_move`  in  8  black move, {row[3:0], col[3:0]}
- `b_req_ready`  out  1  black request accepted when valid & ready
- `w_req_valid` / `w_req_move` / `w_req_ready`: same for white
- `board`  in  2 x [8:0][8:0]  current board from the board FSM, indexed board[row][col]; 00 empty, 01 black, 10 white
- `move_avail`  out  1  one-cycle placement strobe to the board FSM
- `move`  out  8  placement, valid while move_avail
- `move_color`  out  2  01 black, 10 white; valid while move_avail
- `turn`  out  2  color to move (01/10)
- `reject`  out  1  one-cycle pulse: request refused
- `reject_code`  out  2  01 out of range, 10 occupied; held until the next reject
- `timeout`  out  1  one-cycle pulse: turn expired and was converted to a pass
- `game_over`  out  1  level; two consecutive passes occurred

## Operation
- States: WAIT_REQ, CHECK, ISSUE, SETTLE, GAME_OVER.
- `b_req_ready` = (state==WAIT_REQ && turn==01). `w_req_ready` = (state==WAIT_REQ && turn==10). Ready is decoded from registers only, with no path from valid.
- WAIT_REQ:
  - On handshake, latch the move and go to CHECK. Off-turn requests are never accepted and stay pending at the source.
- CHECK: examine the latched move.
  - Pass (== PASS_CODE): increment pass_cnt and go to SETTLE. move_avail is not asserted.
  - row>=BOARD_SIZE or col>=BOARD_SIZE (and not a pass): reject with code 01, return to WAIT_REQ, turn unchanged.
  - board[row][col]!=00: reject with code 10, return to WAIT_REQ, turn unchanged.
  - Otherwise: clear pass_cnt and go to ISSUE.
- ISSUE: move_avail=1, move=latched move, move_color=turn. Then go to SETTLE.
- SETTLE: one cycle that lets the board register update.
  - Toggle turn.
  - If pass_cnt==2, go to GAME_OVER; otherwise go to WAIT_REQ.
  - Reset the turn timer.
- GAME_OVER: game_over=1 and both readies are 0. The only exit is reset.
- Timeout, when TURN_TIMEOUT>0:
  - The timer counts each WAIT_REQ cycle without a handshake.
  - When the timer reaches TURN_TIMEOUT-1 with no handshake that cycle, pulse timeout, increment pass_cnt and go to SETTLE.
  - A handshake in the expiry cycle wins, and no timeout is generated.
- pass_cnt is 2 bits and saturates at 2.
- Reset values: state WAIT_REQ, turn 01, move 8'h00, move_color 00, move_avail 0, reject 0, reject_code 00, timeout 0, game_over 0, pass_cnt 0, timer 0.

## Timing
- Handshake in cycle N, followed by a legal placement:
  - CHECK in N+1.
  - move_avail high in N+2 only.
  - SETTLE in N+3.
  - Next player's ready high in N+4.
- Pass: CHECK in N+1, SETTLE in N+2, next ready in N+3.
- Reject: CHECK in N+1. The reject pulse and same-player ready are both high in N+2.
- Timeout: the timeout pulse is in the expiry cycle E. SETTLE is in E+1 and the next ready in E+2.
- Board sampling: board is sampled in CHECK. The board FSM updates on the edge ending ISSUE, so the next CHECK always sees the prior placement.
- Reset asserted mid-sequence, for example during ISSUE: move_avail drops immediately and the FSM returns to WAIT_REQ with black to move. No partial move is emitted after release.

## Test plan
- Reset, then black sends 8'h44 held valid: b_req_ready=1 at reset release. After 2 cycles, move_avail=1 for 1 cycle with move=8'h44 and move_color=01. Two cycles later turn=10 and w_req_ready=1.
- White sends 8'h44 onto a board where board[4][4]=01: reject=1 with reject_code=10 in N+2, turn stays 10, move_avail never asserted.
- White sends 8'h92 (row 9): reject with code 01. A subsequent 8'h12 is accepted with move_avail and move=8'h12.
- Black passes (8'hFF), then white passes: no move_avail. game_over=1 after white's SETTLE; both readies are 0 while both valids are held high.
- Black passes, white places 8'h00, black passes: pass_cnt is cleared by the placement, so game_over stays 0 and turn=10.
- TURN_TIMEOUT=8, no requests after reset: timeout pulses in the 8th cycle, turn=10 two cycles later. Repeat for white: game_over=1. Variant: a handshake on the 8th cycle produces no timeout.
